// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit and receive paths.
// Contents: parity mode encodings, transmitter FSM state codes, the
// bit-counter width and a helper that derives clocks per bit.
package uart_pkg;

    // Parity mode encodings used by the PARITY parameter
    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Transmitter FSM states
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Counts up to 8 data bits or 2 stop bits
    localparam int BIT_CNT_W = 3;

    // Integer bit period in clocks; the remainder is dropped
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter shared by the UART paths.
// Counts 0..CLKS_PER_BIT-1 and wraps, pulsing bit_done on the last count.
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset, counter to 0
//   clear    hold the counter at 0 (used while the line is idle)
//   bit_done high on the final clock of a bit period
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 1041
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // Wrapping on bit_done is what reloads the count at each bit/state change
    assign bit_done = (cnt == LAST) && !clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: serialises words from a valid/ready source into
// start / data (LSB first) / optional parity / stop frames.
// Ports:
//   clk_i    system clock, rising edge
//   rst_i    asynchronous active-high reset; aborts any frame
//   data_i   word to send, captured only on a handshake
//   valid_i  source offers data_i
//   ready_o  a word is accepted on this cycle's edge if valid_i is high
//   tx_o     serial line, idle high, driven straight from a flop
//   busy_o   a frame is in progress
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 10000000,
    parameter int BAUD       = 9600,
    parameter int DATA_WIDTH = 7,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic                  tx_o,
    output logic                  busy_o
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

    logic [2:0]            state;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_bit;
    logic                  bit_done;
    logic                  last_stop;
    logic                  xfer;

    function automatic logic parity_of(input logic [DATA_WIDTH-1:0] d);
        return (PARITY == PARITY_ODD) ? ~^d : ^d;
    endfunction

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk_i),
        .rst      (rst_i),
        .clear    (state == ST_IDLE),
        .bit_done (bit_done)
    );

    assign last_stop = (bit_cnt == LAST_STOP);
    // Accepting on the final stop clock lets frames run back-to-back
    assign ready_o   = (state == ST_IDLE) ||
                       ((state == ST_STOP) && bit_done && last_stop);
    assign xfer      = valid_i && ready_o;
    assign busy_o    = (state != ST_IDLE);

    // tx_o is loaded with the level of the bit being entered, so the line
    // changes on the same edge as the state and never glitches.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            tx_o    <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (xfer) begin
                        shreg   <= data_i;
                        par_bit <= parity_of(data_i);
                        bit_cnt <= '0;
                        state   <= ST_START;
                        tx_o    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_done) begin
                        state   <= ST_DATA;
                        bit_cnt <= '0;
                        tx_o    <= shreg[0];
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
                            if (PARITY != PARITY_NONE) begin
                                state <= ST_PARITY;
                                tx_o  <= par_bit;
                            end else begin
                                state <= ST_STOP;
                                tx_o  <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shreg   <= shreg >> 1;
                            // shreg[1] becomes shreg[0] after this shift
                            tx_o    <= shreg[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_done) begin
                        state   <= ST_STOP;
                        bit_cnt <= '0;
                        tx_o    <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_done) begin
                        if (last_stop) begin
                            bit_cnt <= '0;
                            if (xfer) begin
                                shreg   <= data_i;
                                par_bit <= parity_of(data_i);
                                state   <= ST_START;
                                tx_o    <= 1'b0;
                            end else begin
                                state   <= ST_IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx_o  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx. Five instances cover the default frame,
// a fast-baud streaming setup, even and odd parity with 8 data bits, and
// two stop bits. Expected line levels come from a frame model built from
// the word, parity mode and stop count.
module tb_uart_tx;

    localparam int SEL_DEF  = 0;
    localparam int SEL_FAST = 1;
    localparam int SEL_PE   = 2;
    localparam int SEL_PO   = 3;
    localparam int SEL_S2   = 4;
    localparam int CPB_DEF  = 1041;
    localparam int CPB_FAST = 10;

    logic clk = 1'b0;
    logic rst;

    logic       v_d, v_f, v_pe, v_po, v_s2;
    logic [6:0] d_d, d_f, d_s2;
    logic [7:0] d_pe, d_po;
    logic       r_d, r_f, r_pe, r_po, r_s2;
    logic       t_d, t_f, t_pe, t_po, t_s2;
    logic       b_d, b_f, b_pe, b_po, b_s2;

    int n_tests = 0;
    int n_fail  = 0;

    always #50 clk = ~clk;

    uart_tx u_def (
        .clk_i(clk), .rst_i(rst), .data_i(d_d), .valid_i(v_d),
        .ready_o(r_d), .tx_o(t_d), .busy_o(b_d)
    );
    uart_tx #(.BAUD(1000000)) u_fast (
        .clk_i(clk), .rst_i(rst), .data_i(d_f), .valid_i(v_f),
        .ready_o(r_f), .tx_o(t_f), .busy_o(b_f)
    );
    uart_tx #(.BAUD(1000000), .DATA_WIDTH(8), .PARITY(1)) u_pe (
        .clk_i(clk), .rst_i(rst), .data_i(d_pe), .valid_i(v_pe),
        .ready_o(r_pe), .tx_o(t_pe), .busy_o(b_pe)
    );
    uart_tx #(.BAUD(1000000), .DATA_WIDTH(8), .PARITY(2)) u_po (
        .clk_i(clk), .rst_i(rst), .data_i(d_po), .valid_i(v_po),
        .ready_o(r_po), .tx_o(t_po), .busy_o(b_po)
    );
    uart_tx #(.STOP_BITS(2)) u_s2 (
        .clk_i(clk), .rst_i(rst), .data_i(d_s2), .valid_i(v_s2),
        .ready_o(r_s2), .tx_o(t_s2), .busy_o(b_s2)
    );

    function automatic logic tx_of(input int sel);
        case (sel)
            SEL_FAST: return t_f;
            SEL_PE:   return t_pe;
            SEL_PO:   return t_po;
            SEL_S2:   return t_s2;
            default:  return t_d;
        endcase
    endfunction

    function automatic logic rdy_of(input int sel);
        case (sel)
            SEL_FAST: return r_f;
            SEL_PE:   return r_pe;
            SEL_PO:   return r_po;
            SEL_S2:   return r_s2;
            default:  return r_d;
        endcase
    endfunction

    function automatic logic busy_of(input int sel);
        case (sel)
            SEL_FAST: return b_f;
            SEL_PE:   return b_pe;
            SEL_PO:   return b_po;
            SEL_S2:   return b_s2;
            default:  return b_d;
        endcase
    endfunction

    task automatic drive(input int sel, input logic v, input logic [7:0] d);
        case (sel)
            SEL_FAST: begin v_f  = v; d_f  = d[6:0]; end
            SEL_PE:   begin v_pe = v; d_pe = d;      end
            SEL_PO:   begin v_po = v; d_po = d;      end
            SEL_S2:   begin v_s2 = v; d_s2 = d[6:0]; end
            default:  begin v_d  = v; d_d  = d[6:0]; end
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer a word at a falling edge; returns at the falling edge just after
    // the accepting rising edge, with valid dropped.
    task automatic send(input int sel, input logic [7:0] d);
        int w;
        w = 0;
        drive(sel, 1'b1, d);
        while (rdy_of(sel) !== 1'b1 && w < 30000) begin
            @(negedge clk);
            w++;
        end
        chk("send_ready", 32'(rdy_of(sel)), 32'd1);
        @(negedge clk);
        drive(sel, 1'b0, d);
    endtask

    // Compare every clock of one frame against the modelled line, starting at
    // the falling edge right after the accept. poke_k >= 0 offers a different
    // word mid-frame, which must be ignored.
    task automatic check_frame(input int sel, input int cpb, input int dw, input int par,
                               input int stops, input logic [7:0] d, input int poke_k);
        logic bits[$];
        int   total, low_cnt, line_err, busy_err, ones;
        logic last_rdy;
        low_cnt  = 0;
        line_err = 0;
        busy_err = 0;
        last_rdy = 1'b0;
        ones     = $countones(d);
        bits.push_back(1'b0);
        for (int i = 0; i < dw; i++) bits.push_back(d[i]);
        if (par == 1) bits.push_back((ones % 2) == 1);
        if (par == 2) bits.push_back((ones % 2) == 0);
        for (int i = 0; i < stops; i++) bits.push_back(1'b1);
        total = bits.size() * cpb;
        for (int k = 0; k < total; k++) begin
            if (poke_k >= 0 && k == poke_k)     drive(sel, 1'b1, d ^ 8'h5A);
            if (poke_k >= 0 && k == poke_k + 3) drive(sel, 1'b0, d ^ 8'h5A);
            if (tx_of(sel) !== bits[k / cpb]) line_err++;
            if (k % cpb == cpb / 2)
                chk($sformatf("s%0d_bit%0d", sel, k / cpb), 32'(tx_of(sel)),
                    32'(bits[k / cpb]));
            if (rdy_of(sel) === 1'b0) low_cnt++;
            if (busy_of(sel) !== 1'b1) busy_err++;
            last_rdy = rdy_of(sel);
            @(negedge clk);
        end
        chk($sformatf("s%0d_line_errs", sel), 32'(line_err), 32'd0);
        chk($sformatf("s%0d_busy_errs", sel), 32'(busy_err), 32'd0);
        chk($sformatf("s%0d_ready_low", sel), 32'(low_cnt), 32'(total - 1));
        chk($sformatf("s%0d_ready_last", sel), 32'(last_rdy), 32'd1);
        chk($sformatf("s%0d_idle_busy", sel), 32'(busy_of(sel)), 32'd0);
        chk($sformatf("s%0d_idle_ready", sel), 32'(rdy_of(sel)), 32'd1);
        chk($sformatf("s%0d_idle_tx", sel), 32'(tx_of(sel)), 32'd1);
    endtask

    logic [7:0] word;
    logic [6:0] rxq[$];
    logic [6:0] rx_w;
    logic       line, prev, rx_active, taken;
    int         idx, rx_cnt, run, max_gap, started, stop_err, b;

    initial begin
        rst = 1'b1;
        v_d = 1'b1; d_d = 7'h55;
        v_f = 1'b0; d_f = '0;
        v_pe = 1'b0; d_pe = '0;
        v_po = 1'b0; d_po = '0;
        v_s2 = 1'b0; d_s2 = '0;

        // Reset held with valid high: nothing may start
        #10  chk("rst_tx_10", 32'(t_d), 32'd1);
             chk("rst_ready_10", 32'(r_d), 32'd1);
             chk("rst_busy_10", 32'(b_d), 32'd0);
        #50  chk("rst_tx_60", 32'(t_d), 32'd1);
             chk("rst_busy_60", 32'(b_d), 32'd0);
        #50  chk("rst_tx_110", 32'(t_d), 32'd1);
             chk("rst_ready_110", 32'(r_d), 32'd1);
        #10  rst = 1'b0;
        #1   chk("rel_tx", 32'(t_d), 32'd1);
             chk("rel_busy", 32'(b_d), 32'd0);
        // First edge after release accepts 0x55
        @(negedge clk);
        v_d = 1'b0;
        check_frame(SEL_DEF, CPB_DEF, 7, 0, 1, 8'h55, -1);

        // Random word, default frame
        word = 8'($urandom) & 8'h7F;
        send(SEL_DEF, word);
        check_frame(SEL_DEF, CPB_DEF, 7, 0, 1, word, -1);

        // Mid-frame data change and valid pulse must be ignored
        send(SEL_DEF, 8'h2A);
        check_frame(SEL_DEF, CPB_DEF, 7, 0, 1, 8'h2A, 3000);
        repeat (5) @(negedge clk);
        chk("stab_no_second", 32'(b_d), 32'd0);

        // Abort in data bit 3 (held low), then a clean frame
        word = (8'($urandom) & 8'h77);
        send(SEL_DEF, word);
        repeat (4 * CPB_DEF + 500) @(negedge clk);
        chk("abort_pre_tx", 32'(t_d), 32'd0);
        rst = 1'b1;
        #1 chk("abort_tx", 32'(t_d), 32'd1);
           chk("abort_ready", 32'(r_d), 32'd1);
           chk("abort_busy", 32'(b_d), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_abort_tx", 32'(t_d), 32'd1);
        chk("post_abort_busy", 32'(b_d), 32'd0);
        send(SEL_DEF, 8'h11);
        check_frame(SEL_DEF, CPB_DEF, 7, 0, 1, 8'h11, -1);

        // Two stop bits
        word = 8'($urandom) & 8'h7F;
        send(SEL_S2, word);
        check_frame(SEL_S2, CPB_DEF, 7, 0, 2, word, -1);

        // Parity, 8 data bits
        send(SEL_PE, 8'h07);
        check_frame(SEL_PE, CPB_FAST, 8, 1, 1, 8'h07, -1);
        send(SEL_PO, 8'h07);
        check_frame(SEL_PO, CPB_FAST, 8, 2, 1, 8'h07, -1);
        for (int n = 0; n < 3; n++) begin
            word = 8'($urandom);
            send(SEL_PE, word);
            check_frame(SEL_PE, CPB_FAST, 8, 1, 1, word, -1);
            word = 8'($urandom);
            send(SEL_PO, word);
            check_frame(SEL_PO, CPB_FAST, 8, 2, 1, word, -1);
        end

        // Streaming 0x00..0x1F with valid held; bench receiver decodes
        idx = 0; taken = 1'b0; rx_active = 1'b0; rx_cnt = 0; prev = 1'b1;
        run = 0; max_gap = 0; started = 0; stop_err = 0; rx_w = '0;
        for (int cyc = 0; cyc < 4000 && rxq.size() < 32; cyc++) begin
            line = t_f;
            if (!rx_active && line == 1'b0 && prev == 1'b1) begin
                rx_active = 1'b1;
                rx_cnt = 0;
                if (started != 0 && run > max_gap) max_gap = run;
                started = 1;
            end
            if (line) run++; else run = 0;
            if (rx_active) begin
                if (rx_cnt % CPB_FAST == CPB_FAST / 2) begin
                    b = rx_cnt / CPB_FAST;
                    if (b >= 1 && b <= 7) rx_w[b - 1] = line;
                    if (b == 8) begin
                        if (line !== 1'b1) stop_err++;
                        rxq.push_back(rx_w);
                        rx_active = 1'b0;
                    end
                end
                rx_cnt++;
            end
            prev = line;
            if (taken) idx++;
            v_f = (idx < 32);
            d_f = 7'(idx);
            taken = v_f && (r_f === 1'b1);
            @(negedge clk);
        end
        v_f = 1'b0;
        chk("stream_count", 32'(rxq.size()), 32'd32);
        chk("stream_stop_errs", 32'(stop_err), 32'd0);
        chk("stream_gap", 32'(max_gap), 32'(CPB_FAST));
        for (int i = 0; i < rxq.size(); i++)
            chk($sformatf("stream_word%0d", i), 32'(rxq[i]), 32'(i));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
